// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control opcodes and execute-stage FSM encodings
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - single-cycle combinational ALU datapath with zero detect
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    always_comb begin
        y = a + b;
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            // Shift codes are sequenced by alu_exec; unlisted codes fall back to ADD.
            default: y = a + b;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - ALU execute stage with valid/ready handshakes and a bit-serial shifter
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       aluCtl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    logic [WIDTH-1:0] core_y;
    logic             core_zero;
    logic             ready_st;
    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] shifted;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op   (aluCtl),
        .a    (srcA),
        .b    (srcB),
        .y    (core_y),
        .zero (core_zero)
    );

    assign is_shift = (aluCtl == ALU_SLL) || (aluCtl == ALU_SRL);
    assign amt      = srcB[SHW-1:0];
    // result_q doubles as the shift register while in SHIFT; outValid is low there.
    assign shifted  = left_q ? (result_q << 1) : (result_q >> 1);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        ready_st = 1'b0;

        case (state_q)
            ST_IDLE: ready_st = 1'b1;
            ST_HOLD: ready_st = outReady;
            default: ready_st = 1'b0;
        endcase

        accept = inValid && ready_st;

        case (state_q)
            ST_SHIFT: begin
                result_d = shifted;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_HOLD;
                    zero_d  = (shifted == '0);
                end
            end
            ST_HOLD: begin
                if (outReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // A new accept overrides the HOLD->IDLE return so ops can issue back to back.
        if (accept) begin
            if (is_shift && (amt != '0)) begin
                result_d = srcA;
                cnt_d    = amt;
                left_d   = (aluCtl == ALU_SLL);
                state_d  = ST_SHIFT;
            end else if (is_shift) begin
                result_d = srcA;
                zero_d   = (srcA == '0);
                state_d  = ST_HOLD;
            end else begin
                result_d = core_y;
                zero_d   = core_zero;
                state_d  = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
        end
    end

    assign inReady  = ready_st && rst_n;
    assign outValid = (state_q == ST_HOLD);
    assign result   = result_q;
    assign zero     = zero_q;

endmodule
